// File: rtl/jitter_scan_ctrl.sv
// Scan sequencer time-sharing one jitter engine across NUM_CH monitored signals.
// Each channel slot: settle (engine off), measure window (engine on), one capture cycle.
module jitter_scan_ctrl #(
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned SETTLE_CYCLES    = 16,
  parameter int unsigned WINDOW_CYCLES    = 1024,
  parameter int unsigned JITTER_THRESHOLD = 24,
  localparam int unsigned CH_W            = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              clear,
  input  logic [15:0]       meas_value,
  output logic              meas_enable,
  output logic [CH_W-1:0]   ch_sel,
  output logic              busy,
  output logic              done,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [15:0]       rd_last,
  output logic [15:0]       rd_peak,
  output logic [NUM_CH-1:0] alarm_vec,
  output logic [15:0]       scan_count
);

  localparam int unsigned MaxCnt =
      (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] WindowLast = CntW'(WINDOW_CYCLES - 1);
  localparam logic [15:0] Threshold = 16'(JITTER_THRESHOLD);

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StCapture} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [CH_W-1:0]   r_ch, w_ch_d;
  logic [NUM_CH-1:0] r_mask, w_mask_d;
  logic              w_done_d, w_cap, w_pass_end;
  logic              r_meas_en, r_busy, r_done;
  logic [15:0]       r_scan_count;
  logic [15:0]       r_last [NUM_CH];
  logic [15:0]       r_peak [NUM_CH];
  logic [NUM_CH-1:0] r_alarm;
  logic              w_next_hit;
  logic [CH_W-1:0]   w_next_ch, w_first_ch;

  // Lowest set bit strictly above cur; MSB of the result flags a hit.
  function automatic logic [CH_W:0] f_next_above(input logic [NUM_CH-1:0] mask,
                                                 input logic [CH_W-1:0]   cur);
    logic [CH_W:0] res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) res = {1'b1, CH_W'(i)};
    end
    return res;
  endfunction

  function automatic logic [CH_W-1:0] f_lowest(input logic [NUM_CH-1:0] mask);
    logic [CH_W-1:0] res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) res = CH_W'(i);
    end
    return res;
  endfunction

  assign {w_next_hit, w_next_ch} = f_next_above(r_mask, r_ch);
  assign w_first_ch              = f_lowest(ch_mask);

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_ch_d     = r_ch;
    w_mask_d   = r_mask;
    w_done_d   = 1'b0;
    w_cap      = 1'b0;
    w_pass_end = 1'b0;
    if (abort && (r_state != StIdle)) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            w_mask_d = ch_mask;
            if (|ch_mask) begin
              w_state_d = StSettle;
              w_ch_d    = w_first_ch;
              w_cnt_d   = '0;
            end else begin
              w_done_d = 1'b1;
            end
          end
        end
        StSettle: begin
          if (r_cnt == SettleLast) begin
            w_state_d = StMeasure;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        StMeasure: begin
          if (r_cnt == WindowLast) begin
            w_state_d = StCapture;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        StCapture: begin
          w_cap = 1'b1;
          if (w_next_hit) begin
            w_state_d = StSettle;
            w_ch_d    = w_next_ch;
          end else begin
            w_pass_end = 1'b1;
            if (continuous) begin
              // Re-latch the mask at wrap; an empty mask ends the scan silently.
              w_mask_d = ch_mask;
              if (|ch_mask) begin
                w_state_d = StSettle;
                w_ch_d    = w_first_ch;
              end else begin
                w_state_d = StIdle;
              end
            end else begin
              w_state_d = StIdle;
              w_done_d  = 1'b1;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_ch         <= '0;
      r_mask       <= '0;
      r_meas_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_scan_count <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_ch      <= w_ch_d;
      r_mask    <= w_mask_d;
      r_meas_en <= (w_state_d == StMeasure);
      r_busy    <= (w_state_d != StIdle);
      r_done    <= w_done_d;
      if (w_pass_end) r_scan_count <= r_scan_count + 16'd1;
    end
  end

  // Clear outranks a same-cycle capture so no stale result survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_last[i] <= '0;
        r_peak[i] <= '0;
      end
      r_alarm <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_last[i] <= '0;
        r_peak[i] <= '0;
      end
      r_alarm <= '0;
    end else if (w_cap) begin
      r_last[r_ch] <= meas_value;
      if (meas_value > r_peak[r_ch]) r_peak[r_ch] <= meas_value;
      if (meas_value > Threshold) r_alarm[r_ch] <= 1'b1;
    end
  end

  always_comb begin
    rd_last = '0;
    rd_peak = '0;
    if (int'(rd_ch) < NUM_CH) begin
      rd_last = r_last[rd_ch];
      rd_peak = r_peak[rd_ch];
    end
  end

  assign meas_enable = r_meas_en;
  assign ch_sel      = r_ch;
  assign busy        = r_busy;
  assign done        = r_done;
  assign alarm_vec   = r_alarm;
  assign scan_count  = r_scan_count;

endmodule

// File: tb/tb_jitter_scan_ctrl.sv
// Bench for jitter_scan_ctrl: capture scoreboard plus directed timing, abort, clear and reset checks.
module tb_jitter_scan_ctrl;

  localparam int S = 4;
  localparam int W = 16;
  localparam int Slot = S + W + 1;

  logic        clk, rst, start, abort, continuous, clear;
  logic [3:0]  ch_mask;
  logic [15:0] meas_value;
  logic        meas_enable, busy, done;
  logic [1:0]  ch_sel, rd_ch, rd_req, mon_ch;
  logic [15:0] rd_last, rd_peak, scan_count;
  logic [3:0]  alarm_vec;
  logic        mon_pend, mon_prev_en;

  logic [15:0] chan_val [4];
  logic [15:0] m_last [4];
  logic [15:0] m_peak [4];
  logic [3:0]  m_alarm;

  typedef struct {
    int          ch;
    logic [15:0] last;
    logic [15:0] peak;
    logic [3:0]  alarm;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  jitter_scan_ctrl #(
    .NUM_CH          (4),
    .SETTLE_CYCLES   (S),
    .WINDOW_CYCLES   (W),
    .JITTER_THRESHOLD(24)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .clear      (clear),
    .meas_value (meas_value),
    .meas_enable(meas_enable),
    .ch_sel     (ch_sel),
    .busy       (busy),
    .done       (done),
    .rd_ch      (rd_ch),
    .rd_last    (rd_last),
    .rd_peak    (rd_peak),
    .alarm_vec  (alarm_vec),
    .scan_count (scan_count)
  );

  // Engine model: result follows the currently selected signal.
  assign meas_value = chan_val[ch_sel];
  assign rd_ch      = mon_pend ? mon_ch : rd_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_model(input logic [3:0] mask);
    exp_t e;
    for (int ch = 0; ch < 4; ch++) begin
      if (mask[ch]) begin
        m_last[ch] = chan_val[ch];
        if (chan_val[ch] > m_peak[ch]) m_peak[ch] = chan_val[ch];
        if (chan_val[ch] > 16'd24) m_alarm[ch] = 1'b1;
        e.ch    = ch;
        e.last  = m_last[ch];
        e.peak  = m_peak[ch];
        e.alarm = m_alarm;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic model_zero();
    for (int ch = 0; ch < 4; ch++) begin
      m_last[ch] = '0;
      m_peak[ch] = '0;
    end
    m_alarm = '0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] ch);
    rd_req = ch;
    #1;
    check_eq({tag, "_last"}, rd_last, m_last[ch]);
    check_eq({tag, "_peak"}, rd_peak, m_peak[ch]);
  endtask

  // Single pass; optionally re-pulses start mid-scan, which must be ignored.
  task automatic run_pass(input logic [3:0] mask, input bit poke_start);
    int          cyc;
    logic [15:0] sc0;
    push_model(mask);
    sc0     = scan_count;
    ch_mask = mask;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 2000) begin
      start = (poke_start && cyc == 10);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_eq("pass_done", done, 1);
    check_eq("pass_len", cyc, $countones(mask) * Slot + 1);
    check_eq("pass_count", scan_count, sc0 + 16'd1);
    check_eq("pass_busy_end", busy, 0);
  endtask

  // Scoreboard consumer: a capture is an enable fall while still busy.
  always @(negedge clk) begin
    if (rst) begin
      mon_pend    <= 1'b0;
      mon_prev_en <= 1'b0;
      mon_ch      <= '0;
    end else begin
      if (mon_pend) begin
        check_eq("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          check_eq("cap_ch", mon_ch, sb_q[0].ch);
          check_eq("cap_last", rd_last, sb_q[0].last);
          check_eq("cap_peak", rd_peak, sb_q[0].peak);
          check_eq("cap_alarm", alarm_vec, sb_q[0].alarm);
          sb_q.delete(0);
        end
        mon_pend <= 1'b0;
      end
      if (mon_prev_en && !meas_enable && busy) begin
        mon_pend <= 1'b1;
        mon_ch   <= ch_sel;
      end
      mon_prev_en <= meas_enable;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] sc0;
    int          done_cnt;
    int          k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; clear = 1'b0;
    ch_mask = '0; rd_req = '0;
    chan_val[0] = 16'd5; chan_val[1] = 16'd30; chan_val[2] = 16'd40; chan_val[3] = 16'd3;
    model_zero();
    repeat (3) @(negedge clk);
    check_eq("rst_en", meas_enable, 0);
    check_eq("rst_sel", ch_sel, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_alarm", alarm_vec, 0);
    check_eq("rst_count", scan_count, 0);
    check_eq("rst_last", rd_last, 0);
    check_eq("rst_peak", rd_peak, 0);
    rst = 1'b0;
    @(negedge clk);

    // Cycle-exact single pass over ch0 and ch2.
    push_model(4'b0101);
    ch_mask = 4'b0101;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      check_eq($sformatf("sp_en_c%0d", c), meas_enable,
               ((c >= 5 && c <= 20) || (c >= 26 && c <= 41)));
      check_eq($sformatf("sp_sel_c%0d", c), ch_sel, (c <= 21) ? 0 : 2);
      check_eq($sformatf("sp_busy_c%0d", c), busy, (c <= 42));
      check_eq($sformatf("sp_done_c%0d", c), done, (c == 43));
      @(negedge clk);
    end
    check_eq("sp_count", scan_count, 1);
    check_eq("sp_alarm", alarm_vec, 4'b0100);

    // Peak/alarm on ch1: 30 then 10 (second pass ignores a mid-scan start).
    chan_val[1] = 16'd30;
    run_pass(4'b0010, 1'b0);
    chan_val[1] = 16'd10;
    run_pass(4'b0010, 1'b1);
    @(negedge clk);
    read_check("ap_ch1", 2'd1);
    check_eq("ap_last10", rd_last, 16'd10);
    check_eq("ap_peak30", rd_peak, 16'd30);
    check_eq("ap_alarm_sticky", alarm_vec[1], 1);

    // Clear, then exactly-threshold value must not alarm.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_zero();
    check_eq("clr_alarm", alarm_vec, 0);
    read_check("clr_ch2", 2'd2);
    chan_val[1] = 16'd24;
    run_pass(4'b0010, 1'b0);
    check_eq("thr_no_alarm", alarm_vec, 0);

    // Continuous: mask changes mid pass 1; later passes scan ch1 only.
    chan_val[0] = 16'd7;
    chan_val[1] = 16'd50;
    push_model(4'b0001);
    push_model(4'b0010);
    push_model(4'b0010);
    sc0        = scan_count;
    continuous = 1'b1;
    ch_mask    = 4'b0001;
    start      = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 70; c++) begin
      if (done) done_cnt++;
      if (c == 10) ch_mask = 4'b0010;
      if (c == 30) check_eq("cont_sel_ch1", ch_sel, 1);
      abort = (c == 70);
      @(negedge clk);
    end
    abort      = 1'b0;
    continuous = 1'b0;
    check_eq("cont_abort_busy", busy, 0);
    check_eq("cont_abort_en", meas_enable, 0);
    check_eq("cont_count", scan_count, sc0 + 16'd3);
    check_eq("cont_no_done", done_cnt, 0);

    // Abort during MEASURE leaves results and count alone.
    chan_val[0] = 16'd200;
    sc0         = scan_count;
    ch_mask     = 4'b0001;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("ab_measuring", meas_enable, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("ab_en_low", meas_enable, 0);
    check_eq("ab_busy_low", busy, 0);
    done_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check_eq("ab_quiet", done_cnt, 0);
    check_eq("ab_count", scan_count, sc0);
    read_check("ab_ch0", 2'd0);
    run_pass(4'b0001, 1'b0);

    // Zero mask: immediate done, no measurement.
    ch_mask = 4'b0000;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("zm_done", done, 1);
    check_eq("zm_busy", busy, 0);
    check_eq("zm_en", meas_enable, 0);
    @(negedge clk);
    check_eq("zm_done_pulse", done, 0);
    check_eq("zm_en2", meas_enable, 0);

    // Clear coincident with the capture cycle discards the capture.
    chan_val[0] = 16'd99;
    model_zero();
    push_model(4'b0000);
    begin
      exp_t e;
      e.ch = 0; e.last = '0; e.peak = '0; e.alarm = '0;
      sb_q.push_back(e);
    end
    ch_mask = 4'b0001;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("cc_capture_cycle", {busy, meas_enable}, 2'b10);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_eq("cc_done", done, 1);
    check_eq("cc_alarm", alarm_vec, 0);
    @(negedge clk);
    for (int ch = 0; ch < 4; ch++) read_check($sformatf("cc_ch%0d", ch), 2'(ch));

    // Asynchronous reset at a random point mid-scan.
    chan_val[0] = 16'd60; chan_val[1] = 16'd2; chan_val[2] = 16'd33; chan_val[3] = 16'd25;
    push_model(4'b1111);
    ch_mask = 4'b1111;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k     = $urandom_range(2, 80);
    repeat (k) @(negedge clk);
    check_eq("ar_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_en", meas_enable, 0);
    check_eq("ar_sel", ch_sel, 0);
    check_eq("ar_busy", busy, 0);
    check_eq("ar_done", done, 0);
    check_eq("ar_alarm", alarm_vec, 0);
    check_eq("ar_count", scan_count, 0);
    check_eq("ar_last", rd_last, 0);
    check_eq("ar_peak", rd_peak, 0);
    model_zero();
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chan_val[3] = 16'd77;
    run_pass(4'b1000, 1'b0);
    @(negedge clk);
    read_check("ar_rescan", 2'd3);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
